mixcolumns_serial: RTL and testbench
====================================

Name: mixcolumns_serial

Overview:
- Byte-serial AES MixColumns stage; sits directly downstream of the byte-serial shiftrows stage.
- Consumes the shiftrows output stream one byte per clock, column-major: byte 0 of a column is row 0.
- Collects each 4-byte column, applies the MixColumns matrix over GF(2^8), and streams the 4 result bytes out.
- Sustains 1 byte/clock. A bypass input passes columns through unmixed for the final AES round.

Parameters:
- WIDTH, 8, data byte width; fixed at 8 and not legal to change.
- COLS, 4, columns per 128-bit state; used only for the outlast flag.

Ports:
- clock  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-high reset.
- inbyte  input  8  state byte from shiftrows, column-major order.
- invalid  input  1  inbyte is valid this cycle; driven by the shiftrows ready.
- bypass  input  1  final round: output = input, no mixing. Sampled with the 4th byte of each column.
- outbyte  output  8  MixColumns result byte, column-major order.
- ready  output  1  outbyte is valid this cycle.
- outlast  output  1  high with the 16th output byte of each state (byte 3 of column 3).

Behaviour:
- Reset (asynchronous, active-high):
  - outbyte=8'h00, ready=0, outlast=0.
  - Input byte counter=0, column counter=0, output counter=0, output buffer empty.
  - Reset mid-column discards the partial column and any pending output bytes.
- Input side:
  - 2-bit byte counter advances only on invalid=1.
  - Bytes 0-2 are shifted into a 3-byte column register.
  - Gaps (invalid=0) hold the counter and the register; there is no timeout.
- Compute:
  - On the cycle with invalid=1 and counter=3, the full column is {reg0, reg1, reg2, inbyte}.
  - Result r0=2a0^3a1^a2^a3, r1=a0^2a1^3a2^a3, r2=a0^a1^2a2^3a3, r3=3a0^a1^a2^2a3.
  - xtime(x) = {x[6:0],1'b0} ^ (x[7] ? 8'h1B : 8'h00); 3x = xtime(x)^x.
  - If bypass=1, r = a unchanged.
  - The 4 results load into a 4-byte output buffer on that clock edge; the byte counter wraps to 0.
- Output side:
  - Output FSM states: IDLE, EMIT0, EMIT1, EMIT2, EMIT3.
  - IDLE -> EMIT0 when the buffer loads. Each EMITk drives outbyte=rk and ready=1 (registered outputs).
  - EMIT3 -> EMIT0 if a new column loads in that same cycle; otherwise EMIT3 -> IDLE.
  - In IDLE: ready=0, outbyte holds its last value.
- Latency: first result byte is registered the cycle after the 4th input byte. With continuous input, output byte k of a column appears exactly 4 clocks after input byte k.
- No overrun: a column completes no sooner than 4 clocks after the previous one. A load during EMIT3 is legal (double-buffer handoff). A load in EMIT0-EMIT2 cannot occur.
- Column counter: 2 bits, increments after each EMIT3. outlast=1 during EMIT3 when the column counter=3; the counter wraps to 0.
- No back-pressure: downstream always accepts.

Decomposition:
- Package aes_pkg: BYTE_W=8, AES_POLY=8'h1B, function xtime, function gmul3, output-state enum.
- One combinational sub-module, mixcolumn_word: 32-bit column in, bypass in, 32-bit column out.
- mixcolumns_serial owns the counters, the column register, the output buffer and the FSM.

Test Plan:
1. Continuous stream d4,bf,5d,30 (invalid=1, bypass=0) -> outbyte 04,66,81,e5 on 4 consecutive cycles, ready=1 each cycle; first output 4 clocks after d4.
2. Full FIPS-197 round-1 state after shiftrows (d4 bf 5d 30 | e0 b4 52 ae | b8 41 11 f1 | 1e 27 98 e5) -> 04 66 81 e5 | e0 cb 19 9a | 48 f8 d3 7a | 28 06 26 4c with no ready gaps. outlast only on 4c. Second state 49,db,87,3b -> 58,4d,ca,f1.
3. Gapped input: column 49,db,87,3b with invalid low 3 cycles between each byte -> same 58,4d,ca,f1. Output starts the cycle after 3b and no output appears early.
4. bypass=1 on column d4,bf,5d,30 -> outbyte d4,bf,5d,30 unchanged.
5. Reset asserted asynchronously after 2 bytes of a column, then released and a fresh column d4,bf,5d,30 sent -> ready low immediately on reset, outputs 04,66,81,e5, no stale bytes.
6. xtime corner column 80,80,80,80 -> outbyte 80,80,80,80 (2x=1b, 3x=9b; 1b^9b^80^80=80).

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES definitions: GF(2^8) helpers and the serial MixColumns output states.
package aes_pkg;

    localparam int BYTE_W = 8;
    localparam logic [BYTE_W-1:0] AES_POLY = 8'h1B;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EMIT0,
        ST_EMIT1,
        ST_EMIT2,
        ST_EMIT3
    } outState_t;

    function automatic logic [BYTE_W-1:0] xtime(input logic [BYTE_W-1:0] x);
        return {x[BYTE_W-2:0], 1'b0} ^ (x[BYTE_W-1] ? AES_POLY : 8'h00);
    endfunction

    function automatic logic [BYTE_W-1:0] gmul3(input logic [BYTE_W-1:0] x);
        return xtime(x) ^ x;
    endfunction

endpackage

// File: rtl/mixcolumn_word.sv
// Combinational MixColumns of one 32-bit column (row 0 in the top byte), with bypass.
module mixcolumn_word
    import aes_pkg::*;
(
    input  logic [4*BYTE_W-1:0] i_column,
    input  logic                i_bypass,
    output logic [4*BYTE_W-1:0] o_column
);

    logic [BYTE_W-1:0] w_a0, w_a1, w_a2, w_a3;
    logic [BYTE_W-1:0] w_r0, w_r1, w_r2, w_r3;

    assign {w_a0, w_a1, w_a2, w_a3} = i_column;

    assign w_r0 = xtime(w_a0) ^ gmul3(w_a1) ^ w_a2 ^ w_a3;
    assign w_r1 = w_a0 ^ xtime(w_a1) ^ gmul3(w_a2) ^ w_a3;
    assign w_r2 = w_a0 ^ w_a1 ^ xtime(w_a2) ^ gmul3(w_a3);
    assign w_r3 = gmul3(w_a0) ^ w_a1 ^ w_a2 ^ xtime(w_a3);

    assign o_column = i_bypass ? i_column : {w_r0, w_r1, w_r2, w_r3};

endmodule

// File: rtl/mixcolumns_serial.sv
// Byte-serial AES MixColumns: gathers a column, mixes it on the 4th byte, streams 4 bytes out.
module mixcolumns_serial
    import aes_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int COLS  = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] inbyte,
    input  logic             invalid,
    input  logic             bypass,
    output logic [WIDTH-1:0] outbyte,
    output logic             ready,
    output logic             outlast
);

    localparam logic [1:0] LAST_COL = 2'(COLS - 1);

    logic [1:0]          r_inCnt;
    logic [3*WIDTH-1:0]  r_colReg;
    logic [3*WIDTH-1:0]  r_outBuf;
    logic [1:0]          r_colCnt;
    outState_t           r_state;

    logic                w_load;
    logic [4*WIDTH-1:0]  w_mixed;

    assign w_load = invalid && (r_inCnt == 2'd3);

    mixcolumn_word u_mix (
        .i_column ({r_colReg, inbyte}),
        .i_bypass (bypass),
        .o_column (w_mixed)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_inCnt  <= 2'd0;
            r_colReg <= '0;
        end else if (invalid) begin
            r_inCnt <= r_inCnt + 2'd1;
            if (!w_load) begin
                r_colReg <= {r_colReg[2*WIDTH-1:0], inbyte};
            end
        end
    end

    // Byte 0 of a fresh result goes straight to outbyte; only bytes 1-3 wait in the buffer.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_outBuf <= '0;
            r_colCnt <= 2'd0;
            outbyte  <= '0;
            ready    <= 1'b0;
            outlast  <= 1'b0;
        end else if (w_load) begin
            r_outBuf <= w_mixed[3*WIDTH-1:0];
            outbyte  <= w_mixed[4*WIDTH-1:3*WIDTH];
            ready    <= 1'b1;
            outlast  <= 1'b0;
            r_state  <= ST_EMIT0;
            if (r_state == ST_EMIT3) begin
                r_colCnt <= r_colCnt + 2'd1;
            end
        end else begin
            case (r_state)
                ST_EMIT0: begin
                    outbyte <= r_outBuf[3*WIDTH-1:2*WIDTH];
                    r_state <= ST_EMIT1;
                end
                ST_EMIT1: begin
                    outbyte <= r_outBuf[2*WIDTH-1:WIDTH];
                    r_state <= ST_EMIT2;
                end
                ST_EMIT2: begin
                    outbyte <= r_outBuf[WIDTH-1:0];
                    outlast <= (r_colCnt == LAST_COL);
                    r_state <= ST_EMIT3;
                end
                ST_EMIT3: begin
                    ready    <= 1'b0;
                    outlast  <= 1'b0;
                    r_colCnt <= r_colCnt + 2'd1;
                    r_state  <= ST_IDLE;
                end
                default: begin
                    ready   <= 1'b0;
                    outlast <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mixcolumns_serial.sv
// Self-checking bench: GF(2^8) matrix model with cycle-exact compare, plus FIPS-197 literal vectors.
module tb_mixcolumns_serial;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] inbyte = 8'h00;
    logic       invalid = 1'b0;
    logic       bypass = 1'b0;
    logic [7:0] outbyte;
    logic       ready;
    logic       outlast;

    int checks = 0;
    int errors = 0;

    logic [7:0] colQ[$];
    logic [7:0] expQ[$];
    logic [7:0] capQ[$];
    bit         capLast[$];
    logic [7:0] expByte = 8'h00;
    logic       expReady = 1'b0;
    logic       expLast = 1'b0;
    int         outCount = 0;

    always #5 clock = ~clock;

    mixcolumns_serial #(.WIDTH(8), .COLS(4)) dut (
        .clock   (clock),
        .reset   (reset),
        .inbyte  (inbyte),
        .invalid (invalid),
        .bypass  (bypass),
        .outbyte (outbyte),
        .ready   (ready),
        .outlast (outlast)
    );

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = (x << 1) ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Circulant matrix: row i is (2,3,1,1) rotated right by i.
    function automatic logic [31:0] mixCol(input logic [31:0] col);
        logic [7:0] a[4];
        logic [7:0] rowBase[4];
        logic [7:0] acc;
        logic [31:0] res;
        rowBase[0] = 8'd2; rowBase[1] = 8'd3; rowBase[2] = 8'd1; rowBase[3] = 8'd1;
        for (int k = 0; k < 4; k++) a[k] = col[31-8*k -: 8];
        res = 32'h0;
        for (int i = 0; i < 4; i++) begin
            acc = 8'h00;
            for (int j = 0; j < 4; j++) acc = acc ^ gmul(rowBase[(j - i + 4) % 4], a[j]);
            res[31-8*i -: 8] = acc;
        end
        return res;
    endfunction

    // Reference: every 4 valid bytes yield 4 results, released one per clock from the next edge.
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            colQ.delete();
            expQ.delete();
            expReady <= 1'b0;
            expByte  <= 8'h00;
            expLast  <= 1'b0;
            outCount <= 0;
        end else begin
            if (invalid) begin
                colQ.push_back(inbyte);
                if (colQ.size() == 4) begin
                    logic [31:0] colWord;
                    logic [31:0] res;
                    colWord = {colQ[0], colQ[1], colQ[2], colQ[3]};
                    res = bypass ? colWord : mixCol(colWord);
                    for (int k = 0; k < 4; k++) expQ.push_back(res[31-8*k -: 8]);
                    colQ.delete();
                end
            end
            if (expQ.size() > 0) begin
                expReady <= 1'b1;
                expByte  <= expQ.pop_front();
                expLast  <= ((outCount % 16) == 15);
                outCount <= outCount + 1;
            end else begin
                expReady <= 1'b0;
                expLast  <= 1'b0;
            end
        end
    end

    always @(negedge clock) begin
        if (!reset) begin
            checks++;
            if (ready !== expReady) begin
                errors++;
                $display("[TB] FAIL ready @%0t: got %b expected %b", $time, ready, expReady);
            end
            checks++;
            if (outbyte !== expByte) begin
                errors++;
                $display("[TB] FAIL outbyte @%0t: got %h expected %h", $time, outbyte, expByte);
            end
            checks++;
            if (outlast !== expLast) begin
                errors++;
                $display("[TB] FAIL outlast @%0t: got %b expected %b", $time, outlast, expLast);
            end
            if (ready === 1'b1) begin
                capQ.push_back(outbyte);
                capLast.push_back(outlast);
            end
        end
    end

    task automatic sendByte(input logic [7:0] b, input logic bp);
        inbyte  = b;
        bypass  = bp;
        invalid = 1'b1;
        @(negedge clock);
        invalid = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        invalid = 1'b0;
        repeat (n) @(negedge clock);
    endtask

    task automatic applyStimulus(input logic [31:0] col, input logic bp, input int gap);
        for (int k = 0; k < 4; k++) begin
            sendByte(col[31-8*k -: 8], bp);
            if (k < 3 && gap > 0) idleCycles(gap);
        end
    endtask

    task automatic doReset();
        #2 reset = 1'b1;
        @(negedge clock);
        #2 reset = 1'b0;
        @(negedge clock);
        capQ.delete();
        capLast.delete();
    endtask

    task automatic checkOutput(input string name, input int base, input logic [31:0] expWord);
        logic [31:0] got;
        checks++;
        if (capQ.size() >= base + 4) got = {capQ[base], capQ[base+1], capQ[base+2], capQ[base+3]};
        else got = 'x;
        if (got !== expWord) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, got, expWord);
        end
    endtask

    task automatic checkCount(input string name, input int want);
        checks++;
        if (capQ.size() != want) begin
            errors++;
            $display("[TB] FAIL %s: got %0d bytes expected %0d", name, capQ.size(), want);
        end
    endtask

    initial begin
        int ones;
        int lastIdx;
        repeat (2) @(negedge clock);
        #2 reset = 1'b0;
        @(negedge clock);

        checks++;
        if (ready !== 1'b0 || outbyte !== 8'h00 || outlast !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_state: got ready=%b out=%h last=%b expected 0/00/0", ready, outbyte, outlast);
        end

        $display("[TB] test 1: single column");
        capQ.delete(); capLast.delete();
        applyStimulus(32'hd4bf5d30, 1'b0, 0);
        idleCycles(6);
        checkCount("t1_count", 4);
        checkOutput("t1_col", 0, 32'h046681e5);

        $display("[TB] test 2: full FIPS-197 state plus one column");
        doReset();
        applyStimulus(32'hd4bf5d30, 1'b0, 0);
        applyStimulus(32'he0b452ae, 1'b0, 0);
        applyStimulus(32'hb84111f1, 1'b0, 0);
        applyStimulus(32'h1e2798e5, 1'b0, 0);
        applyStimulus(32'h49db873b, 1'b0, 0);
        idleCycles(6);
        checkCount("t2_count", 20);
        checkOutput("t2_col0", 0, 32'h046681e5);
        checkOutput("t2_col1", 4, 32'he0cb199a);
        checkOutput("t2_col2", 8, 32'h48f8d37a);
        checkOutput("t2_col3", 12, 32'h2806264c);
        checkOutput("t2_col4", 16, 32'h584dcaf1);
        ones = 0;
        lastIdx = -1;
        foreach (capLast[i]) if (capLast[i]) begin ones++; lastIdx = i; end
        checks++;
        if (ones != 1 || lastIdx != 15) begin
            errors++;
            $display("[TB] FAIL t2_outlast: got %0d flags last at %0d expected 1 flag at 15", ones, lastIdx);
        end

        $display("[TB] test 3: gapped column");
        capQ.delete(); capLast.delete();
        applyStimulus(32'h49db873b, 1'b0, 3);
        checkCount("t3_no_early", 0);
        idleCycles(6);
        checkCount("t3_count", 4);
        checkOutput("t3_col", 0, 32'h584dcaf1);

        $display("[TB] test 4: bypass");
        capQ.delete(); capLast.delete();
        applyStimulus(32'hd4bf5d30, 1'b1, 0);
        idleCycles(6);
        checkCount("t4_count", 4);
        checkOutput("t4_col", 0, 32'hd4bf5d30);

        $display("[TB] test 5: reset mid-column");
        applyStimulus(32'h49db873b, 1'b0, 0);
        sendByte(8'ha5, 1'b0);
        sendByte(8'ha5, 1'b0);
        #2 reset = 1'b1;
        #1;
        checks++;
        if (ready !== 1'b0 || outbyte !== 8'h00) begin
            errors++;
            $display("[TB] FAIL t5_async_reset: got ready=%b out=%h expected 0/00", ready, outbyte);
        end
        @(negedge clock);
        #2 reset = 1'b0;
        @(negedge clock);
        capQ.delete(); capLast.delete();
        applyStimulus(32'hd4bf5d30, 1'b0, 0);
        idleCycles(6);
        checkCount("t5_count", 4);
        checkOutput("t5_col", 0, 32'h046681e5);

        $display("[TB] test 6: xtime corner");
        capQ.delete(); capLast.delete();
        applyStimulus(32'h80808080, 1'b0, 0);
        idleCycles(6);
        checkCount("t6_count", 4);
        checkOutput("t6_col", 0, 32'h80808080);

        $display("[TB] test 7: random stream");
        capQ.delete(); capLast.delete();
        for (int c = 0; c < 48; c++) begin
            logic [31:0] col;
            logic bp;
            col = $urandom;
            bp = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 1) == 0) applyStimulus(col, bp, 0);
            else applyStimulus(col, bp, $urandom_range(1, 2));
            if ($urandom_range(0, 3) == 0) idleCycles($urandom_range(1, 5));
        end
        idleCycles(8);
        checkCount("t7_count", 192);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
